// File: rtl/udsp_pkg.sv
// Shared uDSP definitions: frame sequencer state encoding, sample packing
// constants and the data-memory geometry defaults used by the core.
package udsp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WRITE,
      START,
      RUN
   } seq_state_t;

   localparam int SAMPLE_W  = 24;
   localparam int FRAC_PAD  = 12;
   localparam int DEF_DAW   = 10;
   localparam int DEF_DWW   = 36;
   localparam int RUN_CNT_W = 16;

   // Width of a counter that must be able to hold the value n itself.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/dsp_frame_sequencer.sv
// Per-frame sample exchange with the uDSP data memory, followed by a start
// pulse and a fixed-length program pass during which the side port is released.
module dsp_frame_sequencer
   import udsp_pkg::*;
#(
   parameter int             DAW      = DEF_DAW,
   parameter int             DWW      = DEF_DWW,
   parameter int             SW       = SAMPLE_W,
   parameter int             NCH      = 8,
   parameter logic [DAW-1:0] IN_BASE  = 10'h000,
   parameter logic [DAW-1:0] OUT_BASE = 10'h080,
   parameter int             PROG_LEN = 512
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sample_tick,
   input  logic [NCH*SW-1:0] in_samples,
   output logic [NCH*SW-1:0] out_samples,
   output logic              out_valid,
   output logic              start,
   output logic              mem_own,
   output logic [DAW-1:0]    mem_addr,
   output logic [DWW-1:0]    mem_wdata,
   output logic              mem_we,
   input  logic [DWW-1:0]    mem_rdata,
   output logic              overrun
);

   localparam int                   CW       = cnt_width(NCH);
   localparam logic [CW-1:0]        CNT_NCH  = CW'(NCH);
   localparam logic [CW-1:0]        CNT_LAST = CW'(NCH - 1);
   localparam logic [RUN_CNT_W-1:0] RUN_LAST = RUN_CNT_W'(PROG_LEN - 1);

   seq_state_t           state;
   logic [CW-1:0]        chan_cnt;
   logic [CW-1:0]        chan_next;
   logic [RUN_CNT_W-1:0] run_cnt;
   logic [NCH*SW-1:0]    in_buf;
   logic [NCH*SW-1:0]    rd_buf;
   logic [NCH*SW-1:0]    rd_merged;
   logic [SW-1:0]        rd_word;
   logic [SW-1:0]        wr_sample;
   logic [DWW-1:0]       wr_word;

   assign chan_next = chan_cnt + CW'(1);
   assign rd_word   = mem_rdata[DWW-1 -: SW];
   assign wr_word   = DWW'({wr_sample, {FRAC_PAD{1'b0}}});

   // Sample for the write slot being loaded at the next edge; slot 0 on READ exit.
   always_comb begin
      wr_sample = in_buf[SW-1:0];
      if (state == WRITE && chan_next < CNT_NCH) begin
         wr_sample = in_buf[int'(chan_next)*SW +: SW];
      end
   end

   // The final word arrives in the same cycle out_samples is loaded, so it
   // bypasses the capture buffer.
   always_comb begin
      rd_merged = rd_buf;
      rd_merged[(NCH-1)*SW +: SW] = rd_word;
   end

   // All memory-side outputs are registered and loaded one edge ahead, so the
   // address for slot k is on the port during the cycle chan_cnt == k.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         chan_cnt    <= '0;
         run_cnt     <= '0;
         in_buf      <= '0;
         rd_buf      <= '0;
         out_samples <= '0;
         out_valid   <= 1'b0;
         start       <= 1'b0;
         mem_own     <= 1'b1;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_we      <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         start     <= 1'b0;

         if (sample_tick && state != IDLE) begin
            overrun <= 1'b1;
         end

         case (state)
            IDLE: begin
               mem_own <= 1'b1;
               if (sample_tick) begin
                  in_buf   <= in_samples;
                  chan_cnt <= '0;
                  mem_addr <= OUT_BASE;
                  state    <= READ;
               end
            end

            READ: begin
               if (chan_cnt != '0) begin
                  rd_buf[(int'(chan_cnt)-1)*SW +: SW] <= rd_word;
               end
               if (chan_cnt == CNT_NCH) begin
                  out_samples <= rd_merged;
                  out_valid   <= 1'b1;
                  chan_cnt    <= '0;
                  mem_we      <= 1'b1;
                  mem_addr    <= IN_BASE;
                  mem_wdata   <= wr_word;
                  state       <= WRITE;
               end else begin
                  chan_cnt <= chan_next;
                  mem_addr <= (chan_next == CNT_NCH) ? '0 : OUT_BASE + DAW'(chan_next);
               end
            end

            WRITE: begin
               if (chan_cnt == CNT_LAST) begin
                  chan_cnt  <= '0;
                  mem_we    <= 1'b0;
                  mem_addr  <= '0;
                  mem_wdata <= '0;
                  mem_own   <= 1'b0;
                  start     <= 1'b1;
                  state     <= START;
               end else begin
                  chan_cnt  <= chan_next;
                  mem_addr  <= IN_BASE + DAW'(chan_next);
                  mem_wdata <= wr_word;
               end
            end

            START: begin
               run_cnt <= '0;
               mem_own <= 1'b0;
               state   <= RUN;
            end

            RUN: begin
               if (run_cnt == RUN_LAST) begin
                  run_cnt <= '0;
                  mem_own <= 1'b1;
                  state   <= IDLE;
               end else begin
                  run_cnt <= run_cnt + RUN_CNT_W'(1);
               end
            end

            default: begin
               mem_own <= 1'b1;
               mem_we  <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
